// File: rtl/fifo_rd_pkg.sv
// Shared types and defaults for the async-FIFO read-side drain logic.
package fifo_rd_pkg;

  localparam int unsigned DefDataWidth   = 8;
  localparam int unsigned DefBusyTimeout = 15;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } rd_state_e;

endpackage

// File: rtl/bit_sync2.sv
// Generic two-flop single-bit synchronizer with active-low asynchronous reset.
module bit_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      q_o    <= 1'b0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/fifo_rd_drain.sv
// Pops words from the async FIFO read side and hands them to the UART TX
// with a level valid/busy handshake and a sticky busy-timeout flag.
module fifo_rd_drain
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DefDataWidth,
  parameter int unsigned BUSY_TIMEOUT = DefBusyTimeout
) (
  input  logic                  R_CLK,
  input  logic                  R_RST,
  input  logic                  EN,
  input  logic                  R_EMPTY,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  input  logic                  TX_BUSY,
  output logic                  R_INC,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_DATA_VALID,
  output logic                  TX_ERR
);

  localparam int unsigned    CntW    = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(BUSY_TIMEOUT - 1);

  rd_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic            busy_s;

  bit_sync2 u_busy_sync (
    .clk_i  (R_CLK),
    .rst_ni (R_RST),
    .d_i    (TX_BUSY),
    .q_o    (busy_s)
  );

  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      R_INC         <= 1'b0;
      TX_P_DATA     <= '0;
      TX_DATA_VALID <= 1'b0;
      TX_ERR        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          R_INC <= 1'b0;
          if (EN && !R_EMPTY && !busy_s) begin
            TX_P_DATA     <= RD_DATA;
            TX_DATA_VALID <= 1'b1;
            R_INC         <= 1'b1;
            cnt_q         <= '0;
            state_q       <= SEND;
          end
        end
        SEND: begin
          R_INC <= 1'b0;
          // Busy has priority over the terminal count: an accepted frame is never an error.
          if (busy_s) begin
            TX_DATA_VALID <= 1'b0;
            state_q       <= WAIT_DONE;
          end else if (cnt_q == CntLast) begin
            TX_DATA_VALID <= 1'b0;
            TX_ERR        <= 1'b1;
            state_q       <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          R_INC <= 1'b0;
          if (!busy_s) begin
            state_q <= IDLE;
          end
        end
        default: begin
          R_INC         <= 1'b0;
          TX_DATA_VALID <= 1'b0;
          state_q       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Randomized bench for fifo_rd_drain against a behavioural FIFO/TX/drain model.
module tb_fifo_rd_drain;

  localparam int unsigned Dw = 8;
  localparam int unsigned To = 15;
  localparam int MIdle = 0;
  localparam int MSend = 1;
  localparam int MWait = 2;

  logic          R_CLK   = 1'b0;
  logic          R_RST   = 1'b0;
  logic          EN      = 1'b0;
  logic          R_EMPTY = 1'b1;
  logic [Dw-1:0] RD_DATA = '0;
  logic          TX_BUSY = 1'b0;
  logic          R_INC;
  logic [Dw-1:0] TX_P_DATA;
  logic          TX_DATA_VALID;
  logic          TX_ERR;

  fifo_rd_drain #(
    .DATA_WIDTH   (Dw),
    .BUSY_TIMEOUT (To)
  ) dut (
    .R_CLK         (R_CLK),
    .R_RST         (R_RST),
    .EN            (EN),
    .R_EMPTY       (R_EMPTY),
    .RD_DATA       (RD_DATA),
    .TX_BUSY       (TX_BUSY),
    .R_INC         (R_INC),
    .TX_P_DATA     (TX_P_DATA),
    .TX_DATA_VALID (TX_DATA_VALID),
    .TX_ERR        (TX_ERR)
  );

  always #5 R_CLK = ~R_CLK;

  int checks = 0;
  int passed = 0;

  // Environment: FIFO contents and TX responder.
  logic [Dw-1:0] fifo_q[$];
  bit auto_tx = 1'b0;
  bit no_drop = 1'b0;
  bit tx_drop = 1'b0;
  bit tx_done = 1'b0;
  int tx_delay = 0;
  int tx_hold = 0;
  int hold_cfg = 0;

  // Expected behaviour.
  int            m_state;
  int            m_wait;
  logic          m_inc, m_valid, m_err, m_b1, m_bs;
  logic [Dw-1:0] m_data;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic fifo_drive();
    R_EMPTY = (fifo_q.size() == 0);
    RD_DATA = R_EMPTY ? 8'h00 : fifo_q[0];
  endtask

  task automatic model_reset();
    m_state = MIdle;
    m_wait  = 0;
    m_inc   = 1'b0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_b1    = 1'b0;
    m_bs    = 1'b0;
    m_data  = '0;
  endtask

  task automatic compare();
    check_eq("r_inc", R_INC, m_inc);
    check_eq("tx_valid", TX_DATA_VALID, m_valid);
    check_eq("tx_data", TX_P_DATA, m_data);
    check_eq("tx_err", TX_ERR, m_err);
  endtask

  task automatic tx_update();
    if (!auto_tx) return;
    if (tx_hold > 0) begin
      tx_hold--;
      if (tx_hold == 0) TX_BUSY = 1'b0;
    end else if (m_valid && !tx_done && !tx_drop) begin
      if (tx_delay > 0) tx_delay--;
      else begin
        TX_BUSY = 1'b1;
        tx_done = 1'b1;
        tx_hold = (hold_cfg != 0) ? hold_cfg : int'($urandom_range(1, 20));
      end
    end
  endtask

  task automatic step();
    logic bs_now;
    logic old_inc;
    @(posedge R_CLK);
    old_inc = m_inc;
    bs_now  = m_bs;   // TX_BUSY as seen two edges ago
    m_bs    = m_b1;
    m_b1    = TX_BUSY;
    m_inc   = 1'b0;
    case (m_state)
      MIdle: if (EN && !R_EMPTY && !bs_now) begin
        m_data  = RD_DATA;
        m_valid = 1'b1;
        m_inc   = 1'b1;
        m_wait  = 0;
        m_state = MSend;
      end
      MSend: begin
        if (bs_now) begin
          m_valid = 1'b0;
          m_state = MWait;
        end else if (m_wait == To - 1) begin
          m_valid = 1'b0;
          m_err   = 1'b1;
          m_state = MIdle;
        end else m_wait++;
      end
      default: if (!bs_now) m_state = MIdle;
    endcase
    if (old_inc && fifo_q.size() > 0) void'(fifo_q.pop_front());
    #1;
    compare();
    if (m_inc) begin
      tx_delay = $urandom_range(0, 3);
      tx_drop  = !no_drop && ($urandom_range(0, 7) == 0);
      tx_done  = 1'b0;
    end
    tx_update();
    fifo_drive();
  endtask

  task automatic do_reset(input int cycles);
    #2 R_RST = 1'b0;
    #1;
    fifo_q.delete();
    fifo_drive();
    model_reset();
    tx_hold = 0;
    tx_done = 1'b1;
    compare();
    repeat (cycles) begin
      @(posedge R_CLK);
      #1 compare();
    end
    @(negedge R_CLK);
    R_RST = 1'b1;
  endtask

  int            vcnt;
  int            ninc;
  logic [Dw-1:0] got[$];
  logic [Dw-1:0] burst_exp[3];

  initial begin
    burst_exp = '{8'h11, 8'h22, 8'h33};
    model_reset();
    fifo_q.push_back(8'hFF);
    fifo_drive();
    EN = 1'b1;

    // Reset held with a word available: nothing may move.
    repeat (3) begin
      @(posedge R_CLK);
      #1 compare();
    end
    @(negedge R_CLK);
    R_RST = 1'b1;

    // First pop right after release, then TX never answers -> timeout.
    step();
    check_eq("first_pop_inc", R_INC, 1);
    check_eq("first_pop_data", TX_P_DATA, 8'hFF);
    vcnt = 1;
    repeat (19) begin
      step();
      if (TX_DATA_VALID) vcnt++;
    end
    check_eq("timeout_valid_cycles", vcnt, To);
    check_eq("timeout_err", TX_ERR, 1);

    // Single word, TX_BUSY raised by hand: valid falls on the third edge.
    fifo_q.push_back(8'hA5);
    fifo_drive();
    step();
    check_eq("a5_inc", R_INC, 1);
    check_eq("a5_data", TX_P_DATA, 8'hA5);
    step();
    check_eq("a5_inc_one_cycle", R_INC, 0);
    TX_BUSY = 1'b1;
    step();
    step();
    check_eq("a5_valid_edge2", TX_DATA_VALID, 1);
    step();
    check_eq("a5_valid_edge3", TX_DATA_VALID, 0);
    check_eq("err_sticky", TX_ERR, 1);
    TX_BUSY = 1'b0;
    repeat (4) step();

    // Enable gating.
    EN = 1'b0;
    fifo_q.push_back(8'h3C);
    fifo_q.push_back(8'h4D);
    fifo_drive();
    ninc = 0;
    repeat (50) begin
      step();
      ninc += int'(R_INC);
    end
    check_eq("en_gate_no_inc", ninc, 0);
    EN = 1'b1;
    step();
    check_eq("en_pop_inc", R_INC, 1);
    check_eq("en_pop_data", TX_P_DATA, 8'h3C);
    EN = 1'b0;
    step();
    TX_BUSY = 1'b1;
    ninc = 0;
    repeat (3) begin
      step();
      ninc += int'(R_INC);
    end
    TX_BUSY = 1'b0;
    repeat (4) begin
      step();
      ninc += int'(R_INC);
    end
    check_eq("en_drop_no_new_pop", ninc, 0);
    check_eq("en_drop_frame_done", TX_DATA_VALID, 0);

    // Burst of three with a TX that stays busy 20 cycles per frame.
    fifo_q.delete();
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    fifo_q.push_back(8'h33);
    fifo_drive();
    EN       = 1'b1;
    auto_tx  = 1'b1;
    no_drop  = 1'b1;
    hold_cfg = 20;
    repeat (150) begin
      step();
      if (R_INC) got.push_back(TX_P_DATA);
    end
    check_eq("burst_pops", got.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) check_eq("burst_order", got[i], burst_exp[i]);
    end

    // Mid-frame reset, then no pop until the synchronized busy clears.
    auto_tx = 1'b0;
    TX_BUSY = 1'b0;
    repeat (25) step();
    fifo_q.push_back(8'h77);
    fifo_drive();
    step();
    check_eq("mid_pop", R_INC, 1);
    TX_BUSY = 1'b1;
    do_reset(2);
    repeat (3) step();
    fifo_q.push_back(8'h5A);
    fifo_drive();
    ninc = 0;
    repeat (3) begin
      step();
      ninc += int'(R_INC);
    end
    check_eq("post_reset_busy_no_inc", ninc, 0);
    TX_BUSY = 1'b0;
    ninc = 0;
    repeat (4) begin
      step();
      ninc += int'(R_INC);
    end
    check_eq("post_reset_pop", ninc, 1);

    // Random traffic.
    auto_tx  = 1'b1;
    no_drop  = 1'b0;
    hold_cfg = 0;
    repeat (3000) begin
      EN = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0 && fifo_q.size() < 8) fifo_q.push_back(8'($urandom));
      fifo_drive();
      step();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fifo_rd_drain.md
# fifo_rd_drain

Read-side consumer of the asynchronous FIFO, in the R_CLK domain. Watches the FIFO empty flag and pops one word at a time with a single-cycle R_INC pulse. Holds each popped word in an output register and hands it to the UART transmitter with a level valid/busy handshake. TX_BUSY arrives from the slower TX clock domain and is synchronized inside this block.

## Interface
Parameters:
- DATA_WIDTH, 8: FIFO word and TX_P_DATA width.
- BUSY_TIMEOUT, 15: R_CLK cycles to wait in SEND for TX_BUSY to rise before dropping the frame.

Ports:
- R_CLK, input, 1: read-domain clock.
- R_RST, input, 1: asynchronous, active-low reset.
- EN, input, 1: drain enable. Low blocks new pops; an in-progress frame completes.
- R_EMPTY, input, 1: FIFO empty flag, synchronous to R_CLK.
- RD_DATA, input, DATA_WIDTH: FIFO read data. Combinational from the current read address and valid whenever R_EMPTY=0.
- TX_BUSY, input, 1: transmitter busy. Asynchronous to R_CLK.
- R_INC, output, 1: FIFO pop request. Registered, one cycle wide.
- TX_P_DATA, output, DATA_WIDTH: registered word presented to the transmitter.
- TX_DATA_VALID, output, 1: registered, level. Held until accepted or timed out.
- TX_ERR, output, 1: sticky timeout flag. Cleared only by reset.

## Operation
- busy_s is TX_BUSY passed through a 2-flop synchronizer clocked by R_CLK. The synchronizer resets to 0.
- States: IDLE, SEND, WAIT_DONE.
- IDLE:
  - Advances when EN=1, R_EMPTY=0 and busy_s=0.
  - At that edge: TX_P_DATA<=RD_DATA, TX_DATA_VALID<=1, R_INC<=1, timeout counter<=0, state<=SEND.
  - Otherwise all outputs hold; R_INC=0.
- SEND:
  - R_INC<=0 on the first edge in SEND, so the pulse is exactly one cycle.
  - If busy_s=1: TX_DATA_VALID<=0, state<=WAIT_DONE.
  - Else if counter==BUSY_TIMEOUT-1: TX_DATA_VALID<=0, TX_ERR<=1, state<=IDLE. The frame is lost because it is already popped.
  - Else counter increments.
- WAIT_DONE: when busy_s=0, state<=IDLE.
- TX_P_DATA holds its value until the next capture; it is never cleared except by reset.
- Simultaneous busy_s=1 and terminal count: busy wins, and TX_ERR is not set.
- EN falling in SEND or WAIT_DONE has no effect until the FSM returns to IDLE.
- R_EMPTY is only sampled in IDLE. The FSM spends at least one cycle in SEND, so the FIFO has updated rempty before the next IDLE decision.
- Counter width is clog2(BUSY_TIMEOUT+1). BUSY_TIMEOUT must be at least 2.

## Timing
- Reset (async assert, sync release):
  - R_INC=0, TX_DATA_VALID=0, TX_ERR=0, TX_P_DATA=0.
  - state=IDLE, synchronizer flops=0, counter=0.
- Reset mid-operation aborts immediately. A word already popped is discarded.
- Pop latency: R_INC and TX_DATA_VALID rise on the first R_CLK edge after EN=1, R_EMPTY=0 and busy_s=0 are all true.
- TX_BUSY sync latency is 2 R_CLK edges.
- TX_DATA_VALID falls 1 edge after busy_s rises, so 3 edges after TX_BUSY rises.
- Idle-to-idle minimum per word is 3 cycles (IDLE, SEND, WAIT_DONE), plus the synchronizer delay on each busy edge.
- Back-to-back: a new pop may occur on the edge after WAIT_DONE exits to IDLE.

## Structure
- Shared package fifo_rd_pkg holds:
  - the state enum (IDLE=2'd0, SEND=2'd1, WAIT_DONE=2'd2);
  - DATA_WIDTH and BUSY_TIMEOUT defaults.
- One sub-module, bit_sync2: a generic 2-flop single-bit synchronizer with active-low async reset, also reusable elsewhere.
- The FSM, counter and output registers live in fifo_rd_drain.

## Test plan
- Reset: hold R_RST=0 with R_EMPTY=0 and RD_DATA=8'hFF -> all outputs 0 and no R_INC. Release -> first pop 1 cycle later.
- Single word: RD_DATA=8'hA5, R_EMPTY=0, TX_BUSY=0 -> next edge TX_P_DATA=8'hA5, TX_DATA_VALID=1, R_INC=1 for one cycle only. Then raise TX_BUSY -> TX_DATA_VALID=0 three edges later.
- Burst: FIFO holds 8'h11, 8'h22, 8'h33; TX model holds BUSY for 20 cycles per frame -> exactly 3 R_INC pulses, data presented in order, and no R_INC while busy_s=1.
- Timeout: TX_BUSY tied 0 with one word queued -> TX_DATA_VALID high for exactly 15 cycles, then 0, TX_ERR=1. A second word is still sent and TX_ERR stays 1.
- Enable gating: EN=0 with R_EMPTY=0 for 50 cycles -> no R_INC. EN=1 -> pop on the next edge. Dropping EN in SEND still completes the frame.
- Mid-frame reset: assert R_RST in SEND -> TX_DATA_VALID=0 and state=IDLE immediately, with no spurious R_INC after release until busy_s=0 and R_EMPTY=0.
